// File: rtl/noc_flit_depacketizer.sv
// NoC local-port ejection interface: validates header/tail framing and
// destination, strips framing flits and streams payload through a FIFO.
//
// Ports:
//   noc_clk, noc_rst_n            clock, async active-low reset
//   flit_in_valid/ready/flit_in   flit stream from router local output
//   flit_in_is_header/_is_tail    sideband framing flags
//   pl_valid/ready/data/last      payload stream to core (FWFT FIFO)
//   pkt_done                      one-cycle pulse when a packet closes
//   pkt_src_x/y, pkt_type, pkt_len, pkt_err
//                                 info of current/last packet
//   hdr_drop_cnt                  saturating count of junk flits when idle
//   rx_pkt_cnt                    wrapping count of closed packets
module noc_flit_depacketizer #(
    parameter int         DATA_WIDTH  = 64,
    parameter int         ID_X_WIDTH  = 4,
    parameter int         ID_Y_WIDTH  = 4,
    parameter int         X_ID        = 0,
    parameter int         Y_ID        = 0,
    parameter int         TYPE_WIDTH  = 2,
    parameter int         ORDER_WIDTH = 4,
    parameter int         LEN_WIDTH   = 8,
    parameter logic [3:0] HEAD_H      = 4'hA,
    parameter logic [3:0] HEAD_E      = 4'h5,
    parameter logic [3:0] TAIL_H      = 4'hC,
    parameter logic [3:0] TAIL_E      = 4'h3,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  flit_in_valid,
    output logic                  flit_in_ready,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  flit_in_is_header,
    input  logic                  flit_in_is_tail,
    output logic                  pl_valid,
    input  logic                  pl_ready,
    output logic [DATA_WIDTH-1:0] pl_data,
    output logic                  pl_last,
    output logic                  pkt_done,
    output logic [ID_X_WIDTH-1:0] pkt_src_x,
    output logic [ID_Y_WIDTH-1:0] pkt_src_y,
    output logic [TYPE_WIDTH-1:0] pkt_type,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [2:0]            pkt_err,
    output logic [7:0]            hdr_drop_cnt,
    output logic [15:0]           rx_pkt_cnt
);

    localparam logic [1:0] S_WAIT_HDR  = 2'd0;
    localparam logic [1:0] S_RX_DATA   = 2'd1;
    localparam logic [1:0] S_WAIT_TAIL = 2'd2;
    localparam logic [1:0] S_DISCARD   = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = DATA_WIDTH + 1;

    // Field LSB positions, packed MSB-first from the top of the flit.
    localparam int MH_LSB = DATA_WIDTH - 4;
    localparam int SX_LSB = MH_LSB - ID_X_WIDTH;
    localparam int SY_LSB = SX_LSB - ID_Y_WIDTH;
    localparam int DX_LSB = SY_LSB - ID_X_WIDTH;
    localparam int DY_LSB = DX_LSB - ID_Y_WIDTH;
    localparam int TY_LSB = DY_LSB - TYPE_WIDTH;
    localparam int OR_LSB = TY_LSB - ORDER_WIDTH;
    localparam int LN_LSB = OR_LSB - LEN_WIDTH;
    localparam int ME_LSB = LN_LSB - 4;

    localparam logic [ID_X_WIDTH-1:0] MY_X    = ID_X_WIDTH'(X_ID);
    localparam logic [ID_Y_WIDTH-1:0] MY_Y    = ID_Y_WIDTH'(Y_ID);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CW-1:0]         FULL_N  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0]         PTR_ONE = AW'(1);

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ID_X_WIDTH-1:0] src_x_q, src_x_d;
    logic [ID_Y_WIDTH-1:0] src_y_q, src_y_d;
    logic [TYPE_WIDTH-1:0] type_q, type_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            err_q, err_d;
    logic                  done_q;
    logic [7:0]            drop_q, drop_d;
    logic [15:0]           rx_q;

    logic [PW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  fifo_full;
    logic                  push, push_last, pop, close;

    logic [3:0]            f_mh, f_me;
    logic [ID_X_WIDTH-1:0] f_sx, f_dx;
    logic [ID_Y_WIDTH-1:0] f_sy, f_dy;
    logic [TYPE_WIDTH-1:0] f_ty;
    logic [LEN_WIDTH-1:0]  f_len;
    logic                  accept, hdr_ok, dst_ok, tail_ok;
    logic [PW-1:0]         rd_word;
    logic                  unused_bits;

    assign f_mh  = flit_in[MH_LSB +: 4];
    assign f_sx  = flit_in[SX_LSB +: ID_X_WIDTH];
    assign f_sy  = flit_in[SY_LSB +: ID_Y_WIDTH];
    assign f_dx  = flit_in[DX_LSB +: ID_X_WIDTH];
    assign f_dy  = flit_in[DY_LSB +: ID_Y_WIDTH];
    assign f_ty  = flit_in[TY_LSB +: TYPE_WIDTH];
    assign f_len = flit_in[LN_LSB +: LEN_WIDTH];
    assign f_me  = flit_in[ME_LSB +: 4];

    // Order field and padding carry nothing the ejection side needs.
    assign unused_bits = ^{flit_in[OR_LSB +: ORDER_WIDTH],
                           flit_in[ME_LSB-1:0]};

    assign fifo_full = (count_q == FULL_N);

    // Ready only depends on registered state, never on flit_in_valid.
    assign flit_in_ready = (state_q != S_RX_DATA) | ~fifo_full;
    assign accept        = flit_in_valid & flit_in_ready;

    assign hdr_ok  = flit_in_is_header & (f_mh == HEAD_H)
                   & (f_me == HEAD_E);
    assign dst_ok  = (f_dx == MY_X) & (f_dy == MY_Y);
    assign tail_ok = (f_mh == TAIL_H) & (f_me == TAIL_E)
                   & (f_sx == src_x_q) & (f_sy == src_y_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_x_d   = src_x_q;
        src_y_d   = src_y_q;
        type_d    = type_q;
        len_d     = len_q;
        err_d     = err_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_last = 1'b0;
        close     = 1'b0;
        unique case (state_q)
            S_WAIT_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        src_x_d = f_sx;
                        src_y_d = f_sy;
                        type_d  = f_ty;
                        len_d   = f_len;
                        err_d   = 3'b000;
                        cnt_d   = '0;
                        if (!dst_ok) begin
                            err_d   = 3'b100;
                            state_d = S_DISCARD;
                        end else if (f_len == '0) begin
                            state_d = S_WAIT_TAIL;
                        end else begin
                            state_d = S_RX_DATA;
                        end
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            S_RX_DATA: begin
                if (accept) begin
                    if (flit_in_is_tail) begin
                        // Early tail: queued payload keeps last=0.
                        err_d[1] = 1'b1;
                        close    = 1'b1;
                        state_d  = S_WAIT_HDR;
                    end else begin
                        push      = 1'b1;
                        push_last = (cnt_q == len_q - LEN_ONE);
                        cnt_d     = cnt_q + LEN_ONE;
                        if (push_last) begin
                            state_d = S_WAIT_TAIL;
                        end
                    end
                end
            end
            S_WAIT_TAIL: begin
                if (accept) begin
                    if (!flit_in_is_tail || !tail_ok) begin
                        err_d[0] = 1'b1;
                    end
                    if (flit_in_is_tail) begin
                        close   = 1'b1;
                        state_d = S_WAIT_HDR;
                    end
                end
            end
            S_DISCARD: begin
                if (accept && flit_in_is_tail) begin
                    close   = 1'b1;
                    state_d = S_WAIT_HDR;
                end
            end
            default: state_d = S_WAIT_HDR;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q <= S_WAIT_HDR;
            cnt_q   <= '0;
            src_x_q <= '0;
            src_y_q <= '0;
            type_q  <= '0;
            len_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            type_q  <= type_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= close;
            drop_q  <= drop_d;
            rx_q    <= rx_q + 16'(close);
        end
    end

    // Payload FIFO: storage written on push, read side falls through.
    assign pop = pl_valid & pl_ready;

    always_ff @(posedge noc_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_last, flit_in};
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rd_word  = mem_q[rd_ptr_q];
    assign pl_valid = (count_q != '0);
    // Gate so stale storage never shows on the outputs when empty.
    assign pl_data  = pl_valid ? rd_word[DATA_WIDTH-1:0] : '0;
    assign pl_last  = pl_valid & rd_word[DATA_WIDTH];

    assign pkt_done     = done_q;
    assign pkt_src_x    = src_x_q;
    assign pkt_src_y    = src_y_q;
    assign pkt_type     = type_q;
    assign pkt_len      = len_q;
    assign pkt_err      = err_q;
    assign hdr_drop_cnt = drop_q;
    assign rx_pkt_cnt   = rx_q;

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Randomized bench for noc_flit_depacketizer against a queue-based
// packet-level reference model.
module tb_noc_flit_depacketizer;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n;
    logic        flit_in_valid;
    logic        flit_in_ready;
    logic [63:0] flit_in;
    logic        flit_in_is_header;
    logic        flit_in_is_tail;
    logic        pl_valid;
    logic        pl_ready;
    logic [63:0] pl_data;
    logic        pl_last;
    logic        pkt_done;
    logic [3:0]  pkt_src_x;
    logic [3:0]  pkt_src_y;
    logic [1:0]  pkt_type;
    logic [7:0]  pkt_len;
    logic [2:0]  pkt_err;
    logic [7:0]  hdr_drop_cnt;
    logic [15:0] rx_pkt_cnt;

    noc_flit_depacketizer dut (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .flit_in_valid     (flit_in_valid),
        .flit_in_ready     (flit_in_ready),
        .flit_in           (flit_in),
        .flit_in_is_header (flit_in_is_header),
        .flit_in_is_tail   (flit_in_is_tail),
        .pl_valid          (pl_valid),
        .pl_ready          (pl_ready),
        .pl_data           (pl_data),
        .pl_last           (pl_last),
        .pkt_done          (pkt_done),
        .pkt_src_x         (pkt_src_x),
        .pkt_src_y         (pkt_src_y),
        .pkt_type          (pkt_type),
        .pkt_len           (pkt_len),
        .pkt_err           (pkt_err),
        .hdr_drop_cnt      (hdr_drop_cnt),
        .rx_pkt_cnt        (rx_pkt_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [63:0] f;
        bit          h;
        bit          t;
    } item_t;

    typedef struct {
        logic [63:0] d;
        bit          l;
    } beat_t;

    item_t stim[$];
    beat_t m_q[$];

    int n_vec = 0;
    int n_err = 0;
    int vprob = 100;
    int rprob = 100;
    int n_pop = 0;
    int n_done = 0;

    localparam int P_IDLE = 0;
    localparam int P_DATA = 1;
    localparam int P_TAIL = 2;
    localparam int P_DROP = 3;

    int          ph;
    logic [3:0]  m_sx, m_sy;
    logic [1:0]  m_ty;
    logic [7:0]  m_len, m_cnt, m_drop;
    logic [2:0]  m_err;
    logic        m_done;
    logic [15:0] m_rx;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] mh,
        input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] dx,
        input logic [3:0] dy, input logic [1:0] ty, input logic [7:0] ln,
        input logic [3:0] me);
        logic [3:0] ord;
        ord = 4'($urandom);
        return {mh, sx, sy, dx, dy, ty, ord, ln, me, 26'd0};
    endfunction

    function automatic bit m_ready();
        return (ph != P_DATA) || (m_q.size() < 8);
    endfunction

    task automatic model_reset();
        ph     = P_IDLE;
        m_sx   = '0;
        m_sy   = '0;
        m_ty   = '0;
        m_len  = '0;
        m_cnt  = '0;
        m_err  = '0;
        m_done = 1'b0;
        m_drop = '0;
        m_rx   = '0;
        m_q.delete();
    endtask

    task automatic m_close();
        m_done = 1'b1;
        m_rx   = m_rx + 16'd1;
        ph     = P_IDLE;
    endtask

    task automatic model_flit(input logic [63:0] f, input bit h,
                              input bit t);
        beat_t b;
        case (ph)
            P_IDLE: begin
                if (h && f[63:60] == 4'hA && f[29:26] == 4'h5) begin
                    m_sx  = f[59:56];
                    m_sy  = f[55:52];
                    m_ty  = f[43:42];
                    m_len = f[37:30];
                    m_err = 3'b000;
                    m_cnt = 8'd0;
                    if (f[51:48] != 4'd0 || f[47:44] != 4'd0) begin
                        m_err = 3'b100;
                        ph    = P_DROP;
                    end else begin
                        ph = (m_len == 8'd0) ? P_TAIL : P_DATA;
                    end
                end else if (m_drop < 8'd255) begin
                    m_drop = m_drop + 8'd1;
                end
            end
            P_DATA: begin
                if (t) begin
                    m_err[1] = 1'b1;
                    m_close();
                end else begin
                    m_cnt = m_cnt + 8'd1;
                    b.d = f;
                    b.l = (m_cnt == m_len);
                    m_q.push_back(b);
                    if (b.l) ph = P_TAIL;
                end
            end
            P_TAIL: begin
                if (!t || f[63:60] != 4'hC || f[29:26] != 4'h3 ||
                    f[59:56] != m_sx || f[55:52] != m_sy)
                    m_err[0] = 1'b1;
                if (t) m_close();
            end
            default: begin
                if (t) m_close();
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("flit_in_ready", flit_in_ready, m_ready());
        chk("pl_valid", pl_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("pl_data", pl_data, m_q[0].d);
            chk("pl_last", pl_last, m_q[0].l);
        end
        chk("pkt_done", pkt_done, m_done);
        chk("pkt_src_x", pkt_src_x, m_sx);
        chk("pkt_src_y", pkt_src_y, m_sy);
        chk("pkt_type", pkt_type, m_ty);
        chk("pkt_len", pkt_len, m_len);
        chk("pkt_err", pkt_err, m_err);
        chk("hdr_drop_cnt", hdr_drop_cnt, m_drop);
        chk("rx_pkt_cnt", rx_pkt_cnt, m_rx);
    endtask

    // One clock: check at negedge, drive, then predict the next posedge.
    task automatic step();
        bit acc;
        bit pop;
        @(negedge noc_clk);
        check_outputs();
        if (pkt_done === 1'b1) n_done++;
        if (stim.size() != 0 && $urandom_range(99) < vprob) begin
            flit_in_valid     = 1'b1;
            flit_in           = stim[0].f;
            flit_in_is_header = stim[0].h;
            flit_in_is_tail   = stim[0].t;
        end else begin
            flit_in_valid     = 1'b0;
            flit_in           = {$urandom, $urandom};
            flit_in_is_header = 1'($urandom);
            flit_in_is_tail   = 1'($urandom);
        end
        pl_ready = ($urandom_range(99) < rprob);
        acc    = flit_in_valid && m_ready();
        pop    = (m_q.size() != 0) && pl_ready;
        m_done = 1'b0;
        if (pop) begin
            void'(m_q.pop_front());
            n_pop++;
        end
        if (acc) begin
            model_flit(stim[0].f, stim[0].h, stim[0].t);
            void'(stim.pop_front());
        end
    endtask

    task automatic push_item(input logic [63:0] f, input bit h,
                             input bit t);
        item_t it;
        it.f = f;
        it.h = h;
        it.t = t;
        stim.push_back(it);
    endtask

    // tk: 0 good tail, 1 bad end marker, 2 wrong source.
    task automatic gen_pkt(input logic [3:0] sx, input logic [3:0] sy,
        input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] ty,
        input int len, input int nd, input int tk, input logic [63:0] pat);
        logic [3:0] te;
        logic [3:0] tsx;
        push_item(mk(4'hA, sx, sy, dx, dy, ty, 8'(len), 4'h5), 1, 0);
        for (int i = 0; i < nd; i++) begin
            if (pat != 0) push_item(pat * 64'(i + 1), 0, 0);
            else push_item({$urandom, $urandom}, 0, 0);
        end
        te  = (tk == 1) ? 4'h0 : 4'h3;
        tsx = (tk == 2) ? sx ^ 4'h1 : sx;
        push_item(mk(4'hC, tsx, sy, dx, dy, ty, 8'(len), te), 0, 1);
    endtask

    task automatic push_junk(input int n);
        logic [63:0] f;
        for (int i = 0; i < n; i++) begin
            f = {$urandom, $urandom};
            f[63:60] = 4'hF;
            push_item(f, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((stim.size() != 0 || m_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_idle", 64'(stim.size() + m_q.size()), 0);
        repeat (3) step();
    endtask

    task automatic clr_cnt();
        n_pop  = 0;
        n_done = 0;
    endtask

    initial begin
        int n;
        int len, nd;
        noc_rst_n         = 1'b0;
        flit_in_valid     = 1'b0;
        flit_in           = '0;
        flit_in_is_header = 1'b0;
        flit_in_is_tail   = 1'b0;
        pl_ready          = 1'b0;
        model_reset();
        #12;
        check_outputs();
        chk("rst_pl_data", pl_data, 0);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;

        // Good packet, three beats.
        clr_cnt();
        gen_pkt(4'd1, 4'd2, 4'd0, 4'd0, 2'd1, 3, 3, 0,
                64'h1111111111111111);
        run_idle(200);
        chk("tp1_beats", n_pop, 3);
        chk("tp1_done", n_done, 1);
        chk("tp1_len", pkt_len, 3);
        chk("tp1_err", pkt_err, 0);
        chk("tp1_rx", rx_pkt_cnt, 1);

        // Back-pressure: FIFO fills at 8 with 10 data flits.
        clr_cnt();
        rprob = 0;
        gen_pkt(4'd1, 4'd2, 4'd0, 4'd0, 2'd1, 10, 10, 0,
                64'h0101010101010101);
        repeat (20) step();
        chk("tp2_rdy_low", flit_in_ready, 0);
        chk("tp2_plv", pl_valid, 1);
        rprob = 100;
        run_idle(200);
        chk("tp2_beats", n_pop, 10);

        // Foreign destination: everything discarded.
        clr_cnt();
        gen_pkt(4'd5, 4'd6, 4'd3, 4'd3, 2'd2, 2, 2, 0, 0);
        run_idle(200);
        chk("tp3_beats", n_pop, 0);
        chk("tp3_done", n_done, 1);
        chk("tp3_err", pkt_err, 3'b100);

        // Short packet then a good one.
        clr_cnt();
        gen_pkt(4'd1, 4'd1, 4'd0, 4'd0, 2'd0, 4, 2, 0, 0);
        run_idle(200);
        chk("tp4_beats", n_pop, 2);
        chk("tp4_err", pkt_err, 3'b010);
        gen_pkt(4'd2, 4'd2, 4'd0, 4'd0, 2'd3, 2, 2, 0, 0);
        run_idle(200);
        chk("tp4_err_ok", pkt_err, 3'b000);

        // Idle junk then zero-length packet with bad tail marker.
        clr_cnt();
        push_item(64'h0123456789ABCDEF, 0, 0);
        push_item(64'hFEDCBA9876543210, 0, 0);
        gen_pkt(4'd7, 4'd7, 4'd0, 4'd0, 2'd3, 0, 0, 1, 0);
        run_idle(200);
        chk("tp5_drop", hdr_drop_cnt, 2);
        chk("tp5_err", pkt_err, 3'b001);
        chk("tp5_done", n_done, 1);

        // Asynchronous reset with payload queued.
        rprob = 0;
        gen_pkt(4'd2, 4'd3, 4'd0, 4'd0, 2'd1, 6, 6, 0, 0);
        n = 0;
        while (m_q.size() < 3 && n < 50) begin
            step();
            n++;
        end
        @(posedge noc_clk);
        #1;
        chk("rst_pre_plv", pl_valid, 1);
        noc_rst_n     = 1'b0;
        flit_in_valid = 1'b0;
        #1;
        stim.delete();
        model_reset();
        check_outputs();
        chk("rst_mid_pl_data", pl_data, 0);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        rprob = 100;
        gen_pkt(4'd4, 4'd5, 4'd0, 4'd0, 2'd2, 3, 3, 0, 0);
        run_idle(200);
        chk("post_rst_rx", rx_pkt_cnt, 1);
        chk("post_rst_err", pkt_err, 0);

        // Drop counter saturation.
        push_junk(260);
        run_idle(600);
        chk("drop_sat", hdr_drop_cnt, 255);

        // Randomized mixed traffic.
        vprob = 75;
        rprob = 60;
        for (int p = 0; p < 150; p++) begin
            if ($urandom_range(9) == 0) push_junk($urandom_range(1, 3));
            len = $urandom_range(0, 12);
            case ($urandom_range(9))
                0:       nd = (len > 0) ? $urandom_range(0, len - 1) : 0;
                1:       nd = len + $urandom_range(1, 2);
                default: nd = len;
            endcase
            if ($urandom_range(4) == 0)
                gen_pkt(4'($urandom), 4'($urandom), 4'($urandom_range(1, 15)),
                        4'($urandom), 2'($urandom), len, nd, 0, 0);
            else
                gen_pkt(4'($urandom), 4'($urandom), 4'd0, 4'd0,
                        2'($urandom), len, nd,
                        ($urandom_range(7) == 0) ? int'($urandom_range(1, 2)) : 0,
                        0);
        end
        run_idle(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
